// File: rtl/ryuki_datatypes.sv
// Shared core datatypes: identifies which core interface owns a memory transaction.
package ryuki_datatypes;

  typedef enum logic {
    MEM_SRC_INSTR = 1'b0,
    MEM_SRC_DATA  = 1'b1
  } mem_src_t;

endpackage

// File: rtl/mem_arb_resp_fifo.sv
// In-order FIFO of transaction owners; a separate count keeps full and empty distinct.
module mem_arb_resp_fifo
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  mem_src_t         push_id_i,
  input  logic             pop_i,
  output mem_src_t         head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_src_t         slots_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Slot contents are only meaningful below the count, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) slots_q[wr_ptr_q] <= push_id_i;
  end

  assign head_o  = slots_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-port memory between the fetch and data interfaces,
// with in-order response routing back to the owner of each transaction.
module mem_port_arbiter
  import ryuki_datatypes::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               instr_req_i,
  input  logic [ADDR_WIDTH-1:0]              instr_addr_i,
  output logic                               instr_gnt_o,
  output logic                               instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]              instr_rdata_o,
  input  logic                               data_req_i,
  input  logic [ADDR_WIDTH-1:0]              data_addr_i,
  input  logic                               data_we_i,
  input  logic [DATA_WIDTH/8-1:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0]              data_wdata_i,
  output logic                               data_gnt_o,
  output logic                               data_rvalid_o,
  output logic [DATA_WIDTH-1:0]              data_rdata_o,
  output logic                               data_err_o,
  output logic                               mem_req_o,
  output logic [ADDR_WIDTH-1:0]              mem_addr_o,
  output logic                               mem_we_o,
  output logic [DATA_WIDTH/8-1:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  input  logic                               mem_gnt_i,
  input  logic                               mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
  input  logic                               mem_err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                               proto_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  mem_src_t         sel;
  mem_src_t         last_q, last_d;
  mem_src_t         lock_src_q, lock_src_d;
  mem_src_t         head;
  logic             lock_q, lock_d;
  logic             perr_q, perr_d;
  logic             sel_req, full, grant, pop, empty;
  logic [CNT_W-1:0] count;

  always_comb begin
    sel = MEM_SRC_INSTR;
    if (lock_q) begin
      sel = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      sel = (last_q == MEM_SRC_DATA) ? MEM_SRC_INSTR : MEM_SRC_DATA;
    end else if (data_req_i) begin
      sel = MEM_SRC_DATA;
    end
  end

  assign sel_req   = (sel == MEM_SRC_DATA) ? data_req_i : instr_req_i;
  // A pop in the same cycle does not free the slot for issue until the next cycle.
  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  assign mem_req_o = sel_req & ~full;
  assign grant     = mem_req_o & mem_gnt_i;

  always_comb begin
    if (sel == MEM_SRC_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = '1;
      mem_wdata_o = '0;
    end
  end

  assign instr_gnt_o = grant & (sel == MEM_SRC_INSTR);
  assign data_gnt_o  = grant & (sel == MEM_SRC_DATA);

  assign pop            = mem_rvalid_i & ~empty;
  assign instr_rvalid_o = pop & (head == MEM_SRC_INSTR);
  assign data_rvalid_o  = pop & (head == MEM_SRC_DATA);
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  // An ungranted request pins the source so the memory sees a stable request.
  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (grant) begin
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d     = 1'b1;
      lock_src_d = sel;
    end
    last_d = grant ? sel : last_q;
    perr_d = perr_q | (mem_rvalid_i & empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= MEM_SRC_DATA;
      lock_q     <= 1'b0;
      lock_src_q <= MEM_SRC_INSTR;
      perr_q     <= 1'b0;
    end else begin
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      perr_q     <= perr_d;
    end
  end

  mem_arb_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (grant),
    .push_id_i (sel),
    .pop_i     (pop),
    .head_o    (head),
    .count_o   (count),
    .empty_o   (empty)
  );

  assign outstanding_o = count;
  assign proto_err_o   = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a queue-based model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_mem_port_arbiter;

  localparam int MAXO = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic [1:0]  outstanding_o;
  logic        proto_err_o;

  mem_port_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .outstanding_o  (outstanding_o),
    .proto_err_o    (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owners of outstanding transactions (0 = fetch, 1 = data) in issue order.
  int mq[$];
  int m_last = 1;
  bit m_lock = 1'b0;
  int m_lsrc = 0;
  bit m_perr = 1'b0;

  function automatic int m_sel();
    if (m_lock) return m_lsrc;
    if (instr_req_i && !data_req_i) return 0;
    if (data_req_i && !instr_req_i) return 1;
    if (instr_req_i && data_req_i) return 1 - m_last;
    return 0;
  endfunction

  function automatic bit m_issue();
    int s;
    s = m_sel();
    return ((s == 0) ? instr_req_i : data_req_i) && (mq.size() < MAXO);
  endfunction

  int  u_s;
  bit  u_rq, u_g, u_empty;
  always @(posedge clk_i) begin
    if (rst_ni) begin
      u_s     = m_sel();
      u_rq    = m_issue();
      u_g     = u_rq && mem_gnt_i;
      u_empty = (mq.size() == 0);
      if (mem_rvalid_i && u_empty) m_perr = 1'b1;
      if (mem_rvalid_i && !u_empty) void'(mq.pop_front());
      if (u_g) begin
        mq.push_back(u_s);
        m_last = u_s;
        m_lock = 1'b0;
      end else if (u_rq) begin
        m_lock = 1'b1;
        m_lsrc = u_s;
      end
    end
  end

  always @(negedge rst_ni) begin
    mq.delete();
    m_last = 1;
    m_lock = 1'b0;
    m_perr = 1'b0;
  end

  int c_s, c_hd;
  bit c_rq, c_g, c_pop;
  always @(negedge clk_i) begin
    c_s   = m_sel();
    c_rq  = rst_ni && m_issue();
    c_g   = c_rq && mem_gnt_i;
    c_pop = rst_ni && mem_rvalid_i && (mq.size() > 0);
    c_hd  = (mq.size() > 0) ? mq[0] : 0;
    check("mem_req", 32'(mem_req_o), 32'(c_rq));
    check("instr_gnt", 32'(instr_gnt_o), 32'(c_g && c_s == 0));
    check("data_gnt", 32'(data_gnt_o), 32'(c_g && c_s == 1));
    check("instr_rvalid", 32'(instr_rvalid_o), 32'(c_pop && c_hd == 0));
    check("data_rvalid", 32'(data_rvalid_o), 32'(c_pop && c_hd == 1));
    check("data_err", 32'(data_err_o), 32'(c_pop && c_hd == 1 && mem_err_i));
    check("outstanding", 32'(outstanding_o), 32'(mq.size()));
    check("proto_err", 32'(proto_err_o), 32'(m_perr));
    if (c_rq) begin
      check("mem_addr", mem_addr_o, (c_s == 0) ? instr_addr_i : data_addr_i);
      check("mem_we", 32'(mem_we_o), (c_s == 0) ? 32'd0 : 32'(data_we_i));
      check("mem_be", 32'(mem_be_o), (c_s == 0) ? 32'hF : 32'(data_be_i));
      check("mem_wdata", mem_wdata_o, (c_s == 0) ? 32'd0 : data_wdata_i);
    end
    if (c_pop && c_hd == 0) check("instr_rdata", instr_rdata_o, mem_rdata_i);
    if (c_pop && c_hd == 1) check("data_rdata", data_rdata_o, mem_rdata_i);
  end

  // One cycle of stimulus; returns at the following falling edge.
  task automatic cyc(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                     input bit dwe, input logic [3:0] dbe, input logic [31:0] dwd,
                     input bit g, input bit rv, input logic [31:0] rd, input bit er);
    @(posedge clk_i);
    #1;
    instr_req_i  = ir;
    instr_addr_i = ia;
    data_req_i   = dr;
    data_addr_i  = da;
    data_we_i    = dwe;
    data_be_i    = dbe;
    data_wdata_i = dwd;
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    mem_err_i    = er;
    @(negedge clk_i);
  endtask

  task automatic idle(input bit rv, input logic [31:0] rd);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, rv, rd, 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    instr_req_i  = 0;
    data_req_i   = 0;
    mem_gnt_i    = 0;
    mem_rvalid_i = 0;
    mem_err_i    = 0;
    rst_ni       = 0;
    @(negedge clk_i);
    check("rst_outstanding", 32'(outstanding_o), 32'd0);
    check("rst_proto_err", 32'(proto_err_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check("init_mem_req", 32'(mem_req_o), 32'd0);
    check("init_outstanding", 32'(outstanding_o), 32'd0);
    check("init_proto_err", 32'(proto_err_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1;

    // Single fetch
    cyc(1, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("t1_instr_gnt", 32'(instr_gnt_o), 32'd1);
    check("t1_mem_addr", mem_addr_o, 32'h20);
    idle(1, 32'h0000_0013);
    check("t1_instr_rvalid", 32'(instr_rvalid_o), 32'd1);
    check("t1_instr_rdata", instr_rdata_o, 32'h0000_0013);
    check("t1_outstanding1", 32'(outstanding_o), 32'd1);
    idle(0, 0);
    check("t1_outstanding0", 32'(outstanding_o), 32'd0);

    // Contention from reset
    do_reset();
    cyc(1, 32'h40, 1, 32'h200, 0, 4'hF, 0, 1, 0, 0, 0);
    check("t2_gnt0_instr", 32'(instr_gnt_o), 32'd1);
    cyc(1, 32'h44, 1, 32'h204, 0, 4'hF, 0, 1, 1, 32'hA1, 0);
    check("t2_gnt1_data", 32'(data_gnt_o), 32'd1);
    check("t2_rsp0_instr", 32'(instr_rvalid_o), 32'd1);
    cyc(1, 32'h48, 1, 32'h208, 0, 4'hF, 0, 1, 1, 32'hA2, 0);
    check("t2_gnt2_instr", 32'(instr_gnt_o), 32'd1);
    check("t2_rsp1_data", 32'(data_rvalid_o), 32'd1);
    cyc(1, 32'h4C, 1, 32'h20C, 0, 4'hF, 0, 1, 1, 32'hA3, 0);
    check("t2_gnt3_data", 32'(data_gnt_o), 32'd1);
    idle(1, 32'hA4);
    check("t2_rsp3_data", 32'(data_rvalid_o), 32'd1);
    check("t2_rsp3_rdata", data_rdata_o, 32'hA4);

    // Stall lock on a data write
    cyc(0, 32'h60, 1, 32'h100, 1, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0);
    check("t3_addr0", mem_addr_o, 32'h100);
    cyc(1, 32'h60, 1, 32'h100, 1, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0);
    check("t3_addr1", mem_addr_o, 32'h100);
    check("t3_we1", 32'(mem_we_o), 32'd1);
    cyc(1, 32'h60, 1, 32'h100, 1, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0);
    check("t3_addr2", mem_addr_o, 32'h100);
    check("t3_no_instr_gnt", 32'(instr_gnt_o), 32'd0);
    cyc(1, 32'h60, 1, 32'h100, 1, 4'hF, 32'hDEAD_BEEF, 1, 0, 0, 0);
    check("t3_data_gnt", 32'(data_gnt_o), 32'd1);
    cyc(1, 32'h60, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("t3_instr_gnt", 32'(instr_gnt_o), 32'd1);
    idle(1, 32'h0);
    check("t3_rsp_data", 32'(data_rvalid_o), 32'd1);
    idle(1, 32'h55);
    check("t3_rsp_instr", 32'(instr_rvalid_o), 32'd1);

    // Full
    cyc(1, 32'h80, 1, 32'h300, 0, 4'h3, 0, 1, 0, 0, 0);
    check("t4_gnt0_data", 32'(data_gnt_o), 32'd1);
    cyc(1, 32'h84, 1, 32'h300, 0, 4'h3, 0, 1, 0, 0, 0);
    check("t4_gnt1_instr", 32'(instr_gnt_o), 32'd1);
    cyc(1, 32'h88, 1, 32'h304, 0, 4'h3, 0, 1, 0, 0, 0);
    check("t4_full_req", 32'(mem_req_o), 32'd0);
    check("t4_full_cnt", 32'(outstanding_o), 32'd2);
    cyc(1, 32'h88, 1, 32'h304, 0, 4'h3, 0, 1, 1, 32'h77, 0);
    check("t4_pop_req", 32'(mem_req_o), 32'd0);
    check("t4_pop_data", 32'(data_rvalid_o), 32'd1);
    cyc(1, 32'h88, 1, 32'h304, 0, 4'h3, 0, 1, 0, 0, 0);
    check("t4_reissue_req", 32'(mem_req_o), 32'd1);
    check("t4_reissue_data", 32'(data_gnt_o), 32'd1);
    idle(1, 32'h78);
    check("t4_drain_instr", 32'(instr_rvalid_o), 32'd1);
    idle(1, 32'h79);
    check("t4_drain_data", 32'(data_rvalid_o), 32'd1);

    // Error routing
    cyc(0, 0, 1, 32'h400, 0, 4'hF, 0, 1, 0, 0, 0);
    check("t5_data_gnt", 32'(data_gnt_o), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD, 1);
    check("t5_data_rvalid", 32'(data_rvalid_o), 32'd1);
    check("t5_data_err", 32'(data_err_o), 32'd1);
    cyc(1, 32'h24, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("t5_instr_gnt", 32'(instr_gnt_o), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD, 1);
    check("t5_instr_rvalid", 32'(instr_rvalid_o), 32'd1);
    check("t5_no_data_err", 32'(data_err_o), 32'd0);

    // Protocol error, sticky until reset
    idle(1, 32'h99);
    check("t6_no_irv", 32'(instr_rvalid_o), 32'd0);
    check("t6_no_drv", 32'(data_rvalid_o), 32'd0);
    idle(0, 0);
    check("t6_perr_set", 32'(proto_err_o), 32'd1);
    idle(0, 0);
    check("t6_perr_held", 32'(proto_err_o), 32'd1);
    do_reset();

    // Reset with a transaction in flight
    cyc(1, 32'hC0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);
    check("t7_inflight", 32'(outstanding_o), 32'd1);
    do_reset();
    idle(1, 32'h11);
    check("t7_late_irv", 32'(instr_rvalid_o), 32'd0);
    idle(0, 0);
    check("t7_late_perr", 32'(proto_err_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
